// File: rtl/idma_desc64_inflight_tracker.sv
// Request/response register slices between the desc64 frontend and the iDMA backend.
// Caps in-flight transfers and reports occupancy, completions and sticky error/spurious flags.
module idma_desc64_inflight_tracker #(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1),
  parameter type         idma_req_t     = logic,
  parameter type         idma_rsp_t     = struct packed { logic error; }
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  idma_req_t           req_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  output idma_req_t           req_o,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  input  idma_rsp_t           rsp_i,
  input  logic                rsp_valid_i,
  output logic                rsp_ready_o,
  output idma_rsp_t           rsp_o,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  input  logic                clear_i,
  output logic                busy_o,
  output logic [CntWidth-1:0] outstanding_o,
  output logic [31:0]         completed_o,
  output logic                error_o,
  output logic                spurious_o
);

  idma_req_t           req_q;
  idma_rsp_t           rsp_q;
  logic                req_valid_q, rsp_valid_q;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [31:0]         completed_q, completed_d;
  logic                error_q, error_d, spurious_q, spurious_d;
  logic                req_hs, rsp_in_hs, rsp_spurious, rsp_deliver;

  // Handshake decode; no bypass from a same-cycle retire into req_ready_o.
  always_comb begin
    req_ready_o  = (cnt_q != CntWidth'(MaxOutstanding)) && (!req_valid_q || req_ready_i);
    rsp_ready_o  = !rsp_valid_q || rsp_ready_i;
    req_hs       = req_valid_i && req_ready_o;
    rsp_in_hs    = rsp_valid_i && rsp_ready_o;
    rsp_spurious = rsp_in_hs && (cnt_q == '0) && !req_valid_q;
    rsp_deliver  = rsp_valid_q && rsp_ready_i;
  end

  // Occupancy next-state
  always_comb begin
    cnt_d = cnt_q;
    case ({req_hs, rsp_deliver})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Status next-state; clear overrides any coincident set or increment
  always_comb begin
    completed_d = completed_q;
    error_d     = error_q;
    spurious_d  = spurious_q;
    if (clear_i) begin
      completed_d = 32'd0;
      error_d     = 1'b0;
      spurious_d  = 1'b0;
    end else begin
      if (rsp_deliver) begin
        completed_d = completed_q + 32'd1;
      end else begin
        completed_d = completed_q;
      end
      if (rsp_deliver && rsp_q.error) begin
        error_d = 1'b1;
      end else begin
        error_d = error_q;
      end
      if (rsp_spurious) begin
        spurious_d = 1'b1;
      end else begin
        spurious_d = spurious_q;
      end
    end
  end

  // Request and response slices; spurious responses are consumed but never loaded
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_valid_q <= 1'b0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      if (req_hs) begin
        req_valid_q <= 1'b1;
        req_q       <= req_i;
      end else if (req_ready_i) begin
        req_valid_q <= 1'b0;
      end
      if (rsp_in_hs && !rsp_spurious) begin
        rsp_valid_q <= 1'b1;
        rsp_q       <= rsp_i;
      end else if (rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Counters and sticky flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      completed_q <= 32'd0;
      error_q     <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      completed_q <= completed_d;
      error_q     <= error_d;
      spurious_q  <= spurious_d;
    end
  end

  assign req_o         = req_q;
  assign req_valid_o   = req_valid_q;
  assign rsp_o         = rsp_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign busy_o        = (cnt_q != '0);
  assign outstanding_o = cnt_q;
  assign completed_o   = completed_q;
  assign error_o       = error_q;
  assign spurious_o    = spurious_q;

endmodule

// File: tb/tb_idma_desc64_inflight_tracker.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based
// transaction model of the tracker and a simple in-order backend.
module tb_idma_desc64_inflight_tracker;

  localparam int MAXO = 4;

  typedef struct packed { logic [15:0] id; } req_t;
  typedef struct packed { logic [6:0] tag; logic error; } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  req_t        req_i, req_o;
  rsp_t        rsp_i, rsp_o;
  logic        req_valid_i, req_ready_o, req_valid_o, req_ready_i;
  logic        rsp_valid_i, rsp_ready_o, rsp_valid_o, rsp_ready_i;
  logic        clear_i, busy_o, error_o, spurious_o;
  logic [2:0]  outstanding_o;
  logic [31:0] completed_o;

  int checks = 0;
  int errors = 0;

  // Transaction-level model
  int          m_out;
  req_t        m_fwd[$];
  rsp_t        m_rsp[$];
  rsp_t        be_q[$];
  logic [31:0] m_comp;
  bit          m_err, m_spur;

  // Per-cycle drive controls and last-cycle events
  bit d_req_valid, d_req_ready, d_rsp_en, d_rsp_ready, d_clear, d_clear_on_del, d_spur_force, d_err;
  bit g_hs, g_del;
  int n_acc;

  idma_desc64_inflight_tracker #(
    .MaxOutstanding(MAXO),
    .idma_req_t    (req_t),
    .idma_rsp_t    (rsp_t)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_o        (req_o),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .rsp_i        (rsp_i),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_ready_o  (rsp_ready_o),
    .rsp_o        (rsp_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .clear_i      (clear_i),
    .busy_o       (busy_o),
    .outstanding_o(outstanding_o),
    .completed_o  (completed_o),
    .error_o      (error_o),
    .spurious_o   (spurious_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_out = 0;
    m_fwd.delete();
    m_rsp.delete();
    be_q.delete();
    m_comp = 32'd0;
    m_err  = 1'b0;
    m_spur = 1'b0;
  endtask

  task automatic idle_controls();
    d_req_valid = 1'b0; d_req_ready = 1'b0; d_rsp_en = 1'b0; d_rsp_ready = 1'b0;
    d_clear = 1'b0; d_clear_on_del = 1'b0; d_spur_force = 1'b0; d_err = 1'b0;
    req_valid_i = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_ready_i = 1'b0;
    clear_i = 1'b0; req_i = '0; rsp_i = '0;
  endtask

  // One clock: drive, check ready outputs, advance model, check registered outputs.
  task automatic cycle();
    bit   e_req_rdy, e_rsp_rdy, hs, take, rhs, spur, del;
    rsp_t r;
    req_i.id    = 16'($urandom);
    req_valid_i = d_req_valid;
    req_ready_i = d_req_ready;
    rsp_ready_i = d_rsp_ready;
    if (d_spur_force) begin
      rsp_valid_i = 1'b1;
      rsp_i.tag   = 7'($urandom);
      rsp_i.error = 1'($urandom);
    end else begin
      rsp_valid_i = d_rsp_en && (be_q.size() > 0);
      rsp_i       = (be_q.size() > 0) ? be_q[0] : '0;
    end
    clear_i = d_clear || (d_clear_on_del && (m_rsp.size() > 0) && d_rsp_ready);
    #1;
    e_req_rdy = (m_out != MAXO) && ((m_fwd.size() == 0) || req_ready_i);
    e_rsp_rdy = (m_rsp.size() == 0) || rsp_ready_i;
    checks += 2;
    if (req_ready_o !== e_req_rdy) begin
      errors++; $display("FAIL req_ready_o: got %0b expected %0b", req_ready_o, e_req_rdy);
    end
    if (rsp_ready_o !== e_rsp_rdy) begin
      errors++; $display("FAIL rsp_ready_o: got %0b expected %0b", rsp_ready_o, e_rsp_rdy);
    end
    hs   = req_valid_i && e_req_rdy;
    take = (m_fwd.size() > 0) && req_ready_i;
    rhs  = rsp_valid_i && e_rsp_rdy;
    spur = rhs && (m_out == 0) && (m_fwd.size() == 0);
    del  = (m_rsp.size() > 0) && rsp_ready_i;
    @(posedge clk);
    #1;
    if (take) begin
      r.tag   = m_fwd[0].id[6:0];
      r.error = d_err;
      be_q.push_back(r);
      m_fwd.delete(0);
    end
    if (hs) begin
      m_fwd.push_back(req_i);
      m_out++;
      n_acc++;
    end
    if (del) begin
      if (m_rsp[0].error) m_err = 1'b1;
      m_comp = m_comp + 32'd1;
      m_rsp.delete(0);
      m_out--;
    end
    if (rhs) begin
      if (spur) m_spur = 1'b1;
      else m_rsp.push_back(rsp_i);
      if (!d_spur_force) be_q.delete(0);
    end
    if (clear_i) begin
      m_comp = 32'd0; m_err = 1'b0; m_spur = 1'b0;
    end
    g_hs  = hs;
    g_del = del;
    checks += 7;
    if (req_valid_o !== (m_fwd.size() != 0)) begin
      errors++; $display("FAIL req_valid_o: got %0b expected %0b", req_valid_o, m_fwd.size() != 0);
    end
    if (rsp_valid_o !== (m_rsp.size() != 0)) begin
      errors++; $display("FAIL rsp_valid_o: got %0b expected %0b", rsp_valid_o, m_rsp.size() != 0);
    end
    if (outstanding_o !== 3'(m_out)) begin
      errors++; $display("FAIL outstanding_o: got %0d expected %0d", outstanding_o, m_out);
    end
    if (busy_o !== (m_out != 0)) begin
      errors++; $display("FAIL busy_o: got %0b expected %0b", busy_o, m_out != 0);
    end
    if (completed_o !== m_comp) begin
      errors++; $display("FAIL completed_o: got %0d expected %0d", completed_o, m_comp);
    end
    if (error_o !== m_err) begin
      errors++; $display("FAIL error_o: got %0b expected %0b", error_o, m_err);
    end
    if (spurious_o !== m_spur) begin
      errors++; $display("FAIL spurious_o: got %0b expected %0b", spurious_o, m_spur);
    end
    if (m_fwd.size() != 0) begin
      checks++;
      if (req_o !== m_fwd[0]) begin
        errors++; $display("FAIL req_o: got %0h expected %0h", req_o, m_fwd[0]);
      end
    end
    if (m_rsp.size() != 0) begin
      checks++;
      if (rsp_o !== m_rsp[0]) begin
        errors++; $display("FAIL rsp_o: got %0h expected %0h", rsp_o, m_rsp[0]);
      end
    end
  endtask

  task automatic drain();
    int n;
    d_req_valid = 1'b0; d_req_ready = 1'b1; d_rsp_en = 1'b1; d_rsp_ready = 1'b1;
    n = 0;
    while ((m_out != 0 || be_q.size() != 0) && n < 100) begin
      cycle();
      n++;
    end
    checks++;
    if (m_out != 0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL drain_timeout: got busy_o=%0b expected 0", busy_o);
    end
  endtask

  task automatic test_reset();
    idle_controls();
    rst_n = 1'b0;
    #3;
    checks += 6;
    if (req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %0b expected 0", req_valid_o); end
    if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0b expected 0", rsp_valid_o); end
    if (outstanding_o !== 3'd0) begin errors++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding_o); end
    if (completed_o !== 32'd0) begin errors++; $display("FAIL rst_completed: got %0d expected 0", completed_o); end
    if (error_o !== 1'b0) begin errors++; $display("FAIL rst_error: got %0b expected 0", error_o); end
    if (spurious_o !== 1'b0) begin errors++; $display("FAIL rst_spurious: got %0b expected 0", spurious_o); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    idle_controls();
    d_req_ready = 1'b1; d_rsp_en = 1'b1; d_rsp_ready = 1'b1; d_req_valid = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 8; i++) cycle();
    checks++;
    if (n_acc != 8) begin errors++; $display("FAIL b2b_accepts: got %0d expected 8", n_acc); end
    drain();
    checks++;
    if (completed_o !== 32'd8) begin errors++; $display("FAIL b2b_completed: got %0d expected 8", completed_o); end
  endtask

  task automatic test_cap();
    bit seen_del;
    int n;
    idle_controls();
    d_req_ready = 1'b1; d_rsp_ready = 1'b1; d_req_valid = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 8; i++) cycle();
    checks += 3;
    if (n_acc != MAXO) begin errors++; $display("FAIL cap_accepts: got %0d expected %0d", n_acc, MAXO); end
    if (outstanding_o !== 3'(MAXO)) begin errors++; $display("FAIL cap_outstanding: got %0d expected %0d", outstanding_o, MAXO); end
    if (req_ready_o !== 1'b0) begin errors++; $display("FAIL cap_ready: got %0b expected 0", req_ready_o); end
    d_rsp_en = 1'b1;
    seen_del = 1'b0;
    n = 0;
    while (!seen_del && n < 20) begin
      cycle();
      seen_del = g_del;
      n++;
    end
    cycle();
    checks++;
    if (!(seen_del && g_hs && n_acc == MAXO + 1)) begin
      errors++; $display("FAIL cap_refill: got accepts=%0d hs=%0b expected %0d and 1", n_acc, g_hs, MAXO + 1);
    end
    drain();
  endtask

  task automatic test_backpressure();
    req_t held;
    idle_controls();
    d_rsp_en = 1'b1; d_rsp_ready = 1'b1; d_req_valid = 1'b1;
    n_acc = 0;
    cycle();
    held = req_o;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks += 3;
      if (req_o !== held) begin errors++; $display("FAIL bp_stable: got %0h expected %0h", req_o, held); end
      if (req_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b expected 1", req_valid_o); end
      if (req_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready: got %0b expected 0", req_ready_o); end
    end
    checks++;
    if (n_acc != 1) begin errors++; $display("FAIL bp_accepts: got %0d expected 1", n_acc); end
    d_req_valid = 1'b0; d_req_ready = 1'b1;
    cycle();
    checks++;
    if (req_valid_o !== 1'b0) begin errors++; $display("FAIL bp_release: got %0b expected 0", req_valid_o); end
    drain();
  endtask

  task automatic test_error_clear();
    idle_controls();
    d_err = 1'b1; d_req_valid = 1'b1; d_req_ready = 1'b1;
    cycle();
    drain();
    checks++;
    if (error_o !== 1'b1) begin errors++; $display("FAIL err_set: got %0b expected 1", error_o); end
    d_err = 1'b0; d_req_valid = 1'b1;
    cycle();
    d_clear_on_del = 1'b1;
    drain();
    d_clear_on_del = 1'b0;
    checks += 2;
    if (error_o !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b expected 0", error_o); end
    if (completed_o !== 32'd0) begin errors++; $display("FAIL err_clear_completed: got %0d expected 0", completed_o); end
  endtask

  task automatic test_spurious();
    test_reset();
    d_spur_force = 1'b1;
    cycle();
    d_spur_force = 1'b0;
    rsp_valid_i  = 1'b0;
    checks += 3;
    if (spurious_o !== 1'b1) begin errors++; $display("FAIL spur_flag: got %0b expected 1", spurious_o); end
    if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL spur_fwd: got %0b expected 0", rsp_valid_o); end
    if (outstanding_o !== 3'd0) begin errors++; $display("FAIL spur_cnt: got %0d expected 0", outstanding_o); end
  endtask

  task automatic test_reset_midop();
    int n;
    idle_controls();
    d_req_ready = 1'b1; d_rsp_en = 1'b1; d_req_valid = 1'b1;
    cycle();
    cycle();
    d_req_valid = 1'b0;
    n = 0;
    while (m_rsp.size() == 0 && n < 20) begin cycle(); n++; end
    d_req_ready = 1'b0; d_req_valid = 1'b1;
    cycle();
    d_req_valid = 1'b0;
    checks += 3;
    if (outstanding_o !== 3'd3) begin errors++; $display("FAIL mid_pre_cnt: got %0d expected 3", outstanding_o); end
    if (req_valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre_req: got %0b expected 1", req_valid_o); end
    if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre_rsp: got %0b expected 1", rsp_valid_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (req_valid_o !== 1'b0) begin errors++; $display("FAIL mid_req_valid: got %0b expected 0", req_valid_o); end
    if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid: got %0b expected 0", rsp_valid_o); end
    if (outstanding_o !== 3'd0) begin errors++; $display("FAIL mid_outstanding: got %0d expected 0", outstanding_o); end
    if (spurious_o !== 1'b0) begin errors++; $display("FAIL mid_spurious: got %0b expected 0", spurious_o); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b expected 0", busy_o); end
    idle_controls();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    idle_controls();
    for (int i = 0; i < 2000; i++) begin
      d_req_valid = ($urandom_range(0, 3) != 0);
      d_req_ready = ($urandom_range(0, 2) != 0);
      d_rsp_en    = ($urandom_range(0, 2) != 0);
      d_rsp_ready = ($urandom_range(0, 2) != 0);
      d_clear     = ($urandom_range(0, 63) == 0);
      d_err       = ($urandom_range(0, 7) == 0);
      cycle();
    end
    d_clear = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_cap();
    test_backpressure();
    test_error_clear();
    test_spurious();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
